// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
package fetch_queue_pkg;

  localparam int WORD      = 16;
  localparam int AW_DEF    = 16;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fq_state_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular buffer holding {pc, instruction} entries, with flush taking priority.
module fq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = WORD + AW_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible through a valid count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: one outstanding memory read feeding a small queue.
// state | meaning
// RUN   | no request outstanding; issues at fpc when a slot is free
// WAIT  | request outstanding; ack pushes {fpc, data}
// DRAIN | request outstanding but stale after redirect; ack is dropped
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            halt,
  input  logic            redirect,
  input  logic [AW-1:0]   redirect_pc,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic            imem_ack,
  input  logic [WORD-1:0] imem_data,
  output logic            out_valid,
  output logic [WORD-1:0] out_ir,
  output logic [AW-1:0]   out_pc,
  input  logic            out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fq_state_t            state, state_nxt;
  logic [AW-1:0]        fpc, fpc_nxt;
  logic [AW-1:0]        req_addr;
  logic [CW-1:0]        count;
  logic [WORD+AW-1:0]   head;
  logic                 issue, push, pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      fpc      <= '0;
      req_addr <= '0;
    end else begin
      state <= state_nxt;
      fpc   <= fpc_nxt;
      if (issue) req_addr <= fpc;
    end
  end

  always_comb begin
    state_nxt = state;
    fpc_nxt   = fpc;
    issue     = 1'b0;
    push      = 1'b0;
    pop       = out_valid && out_ready;
    imem_req  = 1'b0;
    imem_addr = req_addr;
    case (state)
      RUN: begin
        // A slot is reserved at issue, so an ack can never land in a full queue.
        issue     = !halt && !redirect && (count < FULL);
        imem_req  = issue;
        imem_addr = fpc;
        if (issue) state_nxt = WAIT;
      end
      WAIT: begin
        imem_req = 1'b1;
        if (redirect) begin
          state_nxt = imem_ack ? RUN : DRAIN;
        end else if (imem_ack) begin
          push      = 1'b1;
          fpc_nxt   = fpc + AW'(1);
          state_nxt = RUN;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (redirect) fpc_nxt = redirect_pc;
    if (!reset) imem_req = 1'b0;
  end

  fq_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD + AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({fpc, imem_data}),
    .rdata (head),
    .count (count)
  );

  assign out_valid = (count != '0);
  assign out_ir    = out_valid ? head[WORD-1:0] : '0;
  assign out_pc    = out_valid ? head[WORD+AW-1:WORD] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-level reference model, randomized memory latency and control.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 16;

  logic        clk = 1'b0;
  logic        reset, halt, redirect, imem_req, imem_ack, out_valid, out_ready;
  logic [15:0] redirect_pc, imem_addr, imem_data, out_ir, out_pc;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .out_valid   (out_valid),
    .out_ir      (out_ir),
    .out_pc      (out_pc),
    .out_ready   (out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue contents, next fetch address, one outstanding request.
  logic [31:0] mq[$];
  logic [15:0] m_fpc   = '0;
  logic [15:0] m_paddr = '0;
  bit          m_pend  = 0;
  bit          m_disc  = 0;

  // Memory responder state and observation logs.
  int          age = 0;
  int          lat = 1;
  int          lat_fix = 1;
  bit          lat_rand = 0;
  bit          data_rand = 0;
  logic [15:0] req_log[$];
  logic [31:0] xfer_log[$];

  function automatic logic [31:0] rlog(input int i);
    return (i < req_log.size()) ? 32'(req_log[i]) : 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] xlog(input int i);
    return (i < xfer_log.size()) ? xfer_log[i] : 32'hDEADBEEF;
  endfunction

  always @(negedge clk) begin
    bit exp_req, issue, acked, popv;
    exp_req = reset && (m_pend || (!halt && !redirect && mq.size() < DEPTH));
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", 32'(imem_addr), 32'(m_pend ? m_paddr : m_fpc));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_pc", 32'(out_pc), 32'(mq[0][31:16]));
      chk("out_ir", 32'(out_ir), 32'(mq[0][15:0]));
    end

    if (out_valid && out_ready) xfer_log.push_back({out_pc, out_ir});
    if (imem_req && age == 0) req_log.push_back(imem_addr);
    if (!imem_req || imem_ack) age = 0;
    else age++;

    if (!reset) begin
      mq.delete();
      m_fpc  = '0;
      m_pend = 0;
      m_disc = 0;
    end else begin
      issue = !m_pend && !halt && !redirect && mq.size() < DEPTH;
      acked = m_pend && imem_ack;
      popv  = mq.size() != 0 && out_ready;
      if (redirect) begin
        mq.delete();
        m_fpc = redirect_pc;
        if (acked) begin
          m_pend = 0;
          m_disc = 0;
        end else if (m_pend) begin
          m_disc = 1;
        end
      end else begin
        if (popv) void'(mq.pop_front());
        if (acked) begin
          if (!m_disc) begin
            mq.push_back({m_paddr, imem_data});
            m_fpc = m_fpc + 16'd1;
          end
          m_pend = 0;
          m_disc = 0;
        end
        if (issue) begin
          m_pend  = 1;
          m_paddr = m_fpc;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (imem_req && age >= lat) begin
      imem_ack  = 1'b1;
      imem_data = data_rand ? 16'($urandom) : 16'h1000 + imem_addr;
      lat       = lat_rand ? int'($urandom_range(1, 3)) : lat_fix;
    end else begin
      imem_ack  = 1'b0;
      imem_data = 16'($urandom);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    xfer_log.delete();
  endtask

  task automatic wait_outstanding(input string name, input bit match_addr, input logic [15:0] addr);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc(1);
      if (imem_req && age >= 1 && (!match_addr || imem_addr == addr)) found = 1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  initial begin
    bit found;
    reset = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
    out_ready = 1'b1; imem_ack = 1'b0; imem_data = '0;

    // Reset state and streaming with one-cycle memory.
    cyc(3);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_out_ir", 32'(out_ir), 32'd0);
    chk("rst_out_pc", 32'(out_pc), 32'd0);
    cyc(1);
    reset = 1'b1;
    clear_logs();
    cyc(12);
    chk("s1_nreq", 32'(req_log.size()), 32'd6);
    chk("s1_req0", rlog(0), 32'h0000);
    chk("s1_req1", rlog(1), 32'h0001);
    chk("s1_req2", rlog(2), 32'h0002);
    chk("s1_nxfer", 32'(xfer_log.size()), 32'd5);
    chk("s1_xfer0", xlog(0), 32'h0000_1000);
    chk("s1_xfer1", xlog(1), 32'h0001_1001);

    // Back-pressure: exactly DEPTH requests, then resume on out_ready.
    reset = 1'b0; out_ready = 1'b0;
    cyc(1);
    reset = 1'b1;
    clear_logs();
    cyc(20);
    chk("s2_nreq", 32'(req_log.size()), 32'd4);
    chk("s2_req3", rlog(3), 32'h0003);
    #2;
    chk("s2_full_req", 32'(imem_req), 32'd0);
    chk("s2_full_pc", 32'(out_pc), 32'd0);
    cyc(1);
    out_ready = 1'b1;
    clear_logs();
    cyc(4);
    chk("s2_pop0", xlog(0), 32'h0000_1000);
    chk("s2_next_req", rlog(0), 32'h0004);

    // Redirect while the request for address 2 is outstanding.
    reset = 1'b0; out_ready = 1'b0; lat_fix = 3; lat = 3;
    cyc(1);
    reset = 1'b1;
    clear_logs();
    wait_outstanding("s3_wait_addr2", 1'b1, 16'h0002);
    redirect = 1'b1; redirect_pc = 16'h0040;
    clear_logs();
    cyc(1);
    redirect = 1'b0; out_ready = 1'b1;
    #2;
    chk("s3_flushed", 32'(out_valid), 32'd0);
    cyc(14);
    chk("s3_req0", rlog(0), 32'h0040);
    chk("s3_xfer0", xlog(0), 32'h0040_1040);

    // Redirect coinciding with ack and pop.
    lat_fix = 1; lat = 1; out_ready = 1'b0;
    cyc(6);
    out_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1);
      #2;
      if (imem_ack && imem_req && out_valid) found = 1;
    end
    chk("s4_found", 32'(found), 32'd1);
    redirect = 1'b1; redirect_pc = 16'h0100;
    cyc(1);
    redirect = 1'b0;
    #2;
    chk("s4_empty", 32'(out_valid), 32'd0);
    chk("s4_req", 32'(imem_req), 32'd1);
    chk("s4_addr", 32'(imem_addr), 32'h0100);

    // Address wrap.
    cyc(1);
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    clear_logs();
    cyc(1);
    redirect = 1'b0;
    cyc(12);
    chk("s5_req0", rlog(0), 32'h0000_FFFF);
    chk("s5_req1", rlog(1), 32'h0000_0000);
    chk("s5_xfer0", xlog(0), 32'hFFFF_0FFF);
    chk("s5_xfer1", xlog(1), 32'h0000_1000);

    // Halt with a request outstanding: its ack lands, nothing new issues.
    lat_fix = 3; lat = 3;
    wait_outstanding("s6_wait", 1'b0, 16'h0000);
    halt = 1'b1; out_ready = 1'b0;
    clear_logs();
    cyc(10);
    chk("s6_nreq", 32'(req_log.size()), 32'd0);
    #2;
    chk("s6_req", 32'(imem_req), 32'd0);
    chk("s6_valid", 32'(out_valid), 32'd1);
    cyc(1);
    halt = 1'b0; out_ready = 1'b1;

    // Reset mid-WAIT abandons the request, then fetch restarts at 0.
    wait_outstanding("s7_wait", 1'b0, 16'h0000);
    reset = 1'b0;
    #2;
    chk("s7_req_low", 32'(imem_req), 32'd0);
    cyc(1);
    reset = 1'b1;
    #2;
    chk("s7_valid", 32'(out_valid), 32'd0);
    chk("s7_req", 32'(imem_req), 32'd1);
    chk("s7_addr", 32'(imem_addr), 32'h0000);

    // Randomized traffic against the model.
    lat_rand = 1; data_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      reset       = ($urandom_range(0, 99) != 0);
      halt        = ($urandom_range(0, 9) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom);
      out_ready   = ($urandom_range(0, 9) < 7);
    end
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries buffered (power of two, 2..16).
REQ-002 Parameter AW, default 16, instruction address width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset is synchronous and active-low (reset==0 at posedge clk resets the block).
REQ-005 halt  input  1  processor halted; no new memory requests are issued while high.
REQ-006 redirect  input  1  pulse: fetch stream changes to redirect_pc (jump, jumpf taken, call, ret).
REQ-007 redirect_pc  input  AW  new fetch address, valid when redirect==1.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  AW  read address, stable while imem_req==1.
REQ-010 imem_ack  input  1  read data valid this cycle; completes the outstanding request.
REQ-011 imem_data  input  16  instruction word, valid when imem_ack==1.
REQ-012 out_valid  output  1  head entry available to decode stage.
REQ-013 out_ir  output  16  head instruction word.
REQ-014 out_pc  output  AW  address of head instruction.
REQ-015 out_ready  input  1  decode stage accepts head; transfer when out_valid && out_ready.

Function
REQ-016 States: RUN (no request outstanding), WAIT (request outstanding), DRAIN (outstanding request to be discarded); fpc holds next fetch address.
REQ-017 RUN -> WAIT when !halt && !redirect && (count < DEPTH); imem_req=1, imem_addr=fpc in the same cycle.
REQ-018 In WAIT/DRAIN, imem_req stays 1 and imem_addr unchanged until imem_ack; at most one request outstanding.
REQ-019 WAIT + imem_ack: push {fpc, imem_data}, fpc <= fpc+1 (wraps mod 2^AW, 0xFFFF -> 0x0000), state -> RUN.
REQ-020 Push slot is reserved at issue: a request issues only if count < DEPTH, so the queue never overflows; ack into a full queue is impossible by construction.
REQ-021 Latency: imem_ack at cycle n -> entry at head visible (out_valid=1) at cycle n+1 if queue was empty.
REQ-022 out_valid = (count != 0); out_ir/out_pc driven from head entry; pop on out_valid && out_ready.
REQ-023 Simultaneous push and pop: count unchanged, both take effect.
REQ-024 redirect: count <= 0 (flush, including any same-cycle push and pop), fpc <= redirect_pc; redirect has priority over all other events.
REQ-025 redirect in RUN -> RUN (new request next cycle at redirect_pc); in WAIT without ack -> DRAIN; in WAIT with same-cycle ack -> RUN, ack data discarded.
REQ-026 DRAIN + imem_ack: data discarded, no push, fpc unchanged, -> RUN; a second redirect in DRAIN only updates fpc.
REQ-027 halt does not cancel an outstanding request; its ack pushes normally; queue continues to drain to out_ready.
REQ-028 Address arithmetic is unsigned AW bits; count is log2(DEPTH)+1 bits.

Reset
REQ-029 On reset==0: state=RUN, fpc=0, count=0, head/tail pointers=0, imem_req=0, out_valid=0; outputs out_ir/out_pc=0.
REQ-030 Reset mid-WAIT abandons the request; a late imem_ack after reset is ignored only if it arrives while reset==0; memory is required to drop its request when imem_req falls.
REQ-031 First request issues the cycle after reset deasserts, at address 0.

Structure
REQ-032 Shared package holds WORD (16-bit), AW default, DEPTH default, and the state encoding constants RUN/WAIT/DRAIN.
REQ-033 One sub-module, fq_fifo: DEPTH x (16+AW) circular buffer with push, pop, flush, count; fetch_queue contains the FSM and fpc.

Verification
REQ-034 Reset, out_ready=1, memory acks 1 cycle after each req with data 0x1000+addr -> requests at 0,1,2,...; out_ir=0x1000,0x1001 with out_pc 0,1 in order, no gaps beyond memory latency.
REQ-035 out_ready=0, DEPTH=4 -> exactly 4 requests (addr 0..3), imem_req stays 0 with count=4; raise out_ready -> pop 0x1000 and next request (addr 4) issues.
REQ-036 redirect to 0x0040 while request for addr 2 outstanding (ack 3 cycles later) -> queue empty next cycle, ack data for addr 2 discarded, next request addr 0x0040, out_pc 0x0040 first.
REQ-037 redirect with simultaneous ack and pop -> count=0, no entry pushed, next request at redirect_pc.
REQ-038 redirect_pc=0xFFFF -> fetches 0xFFFF then 0x0000 (wrap).
REQ-039 halt=1 with request outstanding -> ack pushed, no further imem_req; reset==0 mid-WAIT -> imem_req=0, out_valid=0 next cycle, then fetch from 0.
